// File: rtl/aes_pkg.sv
// aes_pkg: AES byte tables, state/FSM types and GF(2^8) helpers shared by the inverse cipher.
package aes_pkg;
  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;
  // Indexed [3-col][3-row] so that FIPS byte (row 0, col 0) lands in bits 127:120.
  typedef byte_t [3:0][3:0] state_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  function automatic byte_t sbox(input byte_t b);
    return SBOX[~b];
  endfunction
  function automatic byte_t inv_sbox(input byte_t b);
    return INV_SBOX[~b];
  endfunction
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/inv_step_round.sv
// inv_step_round: one AES decryption round -- InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless skipped for the last round.
module inv_step_round
  import aes_pkg::*;
(
  input  state_t i_state,
  input  state_t i_key,
  input  logic   i_skip_mix,
  output state_t o_state
);
  state_t w_ak;
  // Packed indices mirror FIPS row/column numbering, so shift and mix offsets run backwards.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_ak[c][r] = inv_sbox(i_state[3 - (r - c + 4) % 4][r]) ^ i_key[c][r];
      assign o_state[c][r] = i_skip_mix ? w_ak[c][r] :
        gmul(w_ak[c][r], 8'h0e) ^ gmul(w_ak[c][(r + 3) % 4], 8'h0b) ^
        gmul(w_ak[c][(r + 2) % 4], 8'h0d) ^ gmul(w_ak[c][(r + 1) % 4], 8'h09);
    end
  end
endmodule

// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher: iterative AES-128 decryption, one round per clock, starting from the
// round-10 key and walking the key schedule backwards on the fly.
module aes128_inv_cipher #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [16*DATA_WIDTH-1:0] in_data,
  input  logic [16*DATA_WIDTH-1:0] in_key,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [16*DATA_WIDTH-1:0] out_data
);
  import aes_pkg::*;
  fsm_t         r_fsm, w_fsm_nxt;
  state_t       r_state, w_round;
  logic [127:0] r_key, w_prev_key;
  logic [31:0]  w_p3;
  logic [3:0]   r_rnd;
  logic         w_accept;
  // Undo one key-schedule step: round rnd words -> round rnd-1 words.
  assign w_p3 = r_key[31:0] ^ r_key[63:32];
  assign w_prev_key[95:0] = r_key[95:0] ^ r_key[127:32];
  assign w_prev_key[127:96] = r_key[127:96] ^ {RCON[r_rnd], 24'h0} ^
    {sbox(w_p3[23:16]), sbox(w_p3[15:8]), sbox(w_p3[7:0]), sbox(w_p3[31:24])};
  inv_step_round u_round (
    .i_state   (r_state),
    .i_key     (w_prev_key),
    .i_skip_mix(r_rnd == 4'd1),
    .o_state   (w_round)
  );
  assign in_ready  = (r_fsm == IDLE) && rst_n;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_fsm == DONE;
  assign out_data  = out_valid ? r_state : '0;
  always_comb begin
    w_fsm_nxt = r_fsm;
    if (w_accept) w_fsm_nxt = ROUND;
    else if (r_fsm == ROUND && r_rnd == 4'd1) w_fsm_nxt = DONE;
    else if (r_fsm == DONE && out_ready) w_fsm_nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) r_fsm <= IDLE;
    else r_fsm <= w_fsm_nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
    end else if (w_accept) begin
      r_state <= in_data ^ in_key;
      r_key   <= in_key;
      r_rnd   <= 4'd10;
    end else if (r_fsm == ROUND) begin
      r_state <= w_round;
      r_key   <= w_prev_key;
      r_rnd   <= r_rnd - 4'd1;
    end
endmodule

// File: tb/tb_aes128_inv_cipher.sv
// tb_aes128_inv_cipher: FIPS and random vectors checked against a forward AES-128 model,
// plus back-pressure, busy-drop, mid-job reset and back-to-back sequences.
module tb_aes128_inv_cipher;
  localparam int NV = 10;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  typedef struct { logic [127:0] ct, key, pt; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [127:0] in_data = '0, in_key = '0, out_data;
  int n_vec = 0, n_bad = 0;
  logic [7:0] sb [256];
  vec_t vecs [NV];

  aes128_inv_cipher #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward AES-128; also returns the last round key, which is what the DUT consumes.
  task automatic encrypt(input logic [127:0] pt, input logic [127:0] k0,
                         output logic [127:0] ct, output logic [127:0] k10);
    logic [31:0] w [44];
    logic [7:0] s [16], t [16], rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] tmp;
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[4*c+r] = sb[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++)
        s[4*c+r] = (rd == 10 ? t[4*c+r] : gm(t[4*c+r], 8'h02) ^ gm(t[4*c+(r+1)%4], 8'h03) ^
                   t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4]) ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    k10 = {w[40], w[41], w[42], w[43]};
  endtask

  task automatic start(input logic [127:0] ct, input logic [127:0] key, output bit rdy);
    @(negedge clk);
    in_data = ct;
    in_key = key;
    in_valid = 1'b1;
    rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit zero_ok);
    lat = 0;
    zero_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      if (out_data !== '0) zero_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic idle_check(input string name);
    bit ok;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready) ok = 1'b0;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, t0, t1, n_out;
    bit ok, rdy, stable, rdy11;
    logic [127:0] pt, hold, d0, d1;
    build_sbox();
    vecs[0] = '{C1_CT, C1_KEY, C1_PT};
    vecs[1] = '{B_CT, B_KEY, B_PT};
    for (int i = 2; i < NV; i++) begin
      logic [127:0] p, k, c, k10;
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      encrypt(p, k, c, k10);
      vecs[i] = '{c, k10, p};
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    for (int i = 0; i < NV; i++) begin
      start(vecs[i].ct, vecs[i].key, rdy);
      wait_valid(lat, ok);
      pt = out_data;
      take();
      chk($sformatf("vec%0d_ready", i), rdy, 1);
      chk($sformatf("vec%0d_pt", i), pt, vecs[i].pt);
      chk($sformatf("vec%0d_latency", i), lat, 10);
      chk($sformatf("vec%0d_zero_until_done", i), ok, 1);
      chk($sformatf("vec%0d_valid_dropped", i), out_valid, 0);
      chk($sformatf("vec%0d_ready_after", i), in_ready, 1);
    end
    start(C1_CT, C1_KEY, rdy);
    wait_valid(lat, ok);
    hold = out_data;
    stable = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_data !== hold) stable = 1'b0;
    end
    chk("bp_pt", hold, C1_PT);
    chk("bp_stable", stable, 1);
    take();
    chk("bp_valid_dropped", out_valid, 0);
    idle_check("bp_single_transfer");
    start(C1_CT, C1_KEY, rdy);
    repeat (2) @(negedge clk);
    in_data = B_CT;
    in_key = B_KEY;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat, ok);
    chk("busy_pt", out_data, C1_PT);
    chk("busy_latency_rest", lat, 5);
    take();
    idle_check("busy_no_queue");
    start(B_CT, B_KEY, rdy);
    wait_valid(lat, ok);
    chk("busy_b_pt", out_data, B_PT);
    take();
    start(C1_CT, C1_KEY, rdy);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_in_ready", in_ready, 1);
    idle_check("abort_no_result");
    start(C1_CT, C1_KEY, rdy);
    wait_valid(lat, ok);
    chk("abort_redo_pt", out_data, C1_PT);
    chk("abort_redo_latency", lat, 10);
    take();
    @(negedge clk);
    in_data = C1_CT;
    in_key = C1_KEY;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_data = B_CT;
    in_key = B_KEY;
    n_out = 0;
    t0 = 0;
    t1 = 0;
    d0 = '0;
    d1 = '0;
    rdy11 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 11) rdy11 = in_ready;
      if (c == 12) in_valid = 1'b0;
      if (out_valid) begin
        if (n_out == 0) begin
          t0 = c;
          d0 = out_data;
        end else begin
          t1 = c;
          d1 = out_data;
        end
        n_out++;
      end
    end
    out_ready = 1'b0;
    chk("b2b_first_pt", d0, C1_PT);
    chk("b2b_first_cycle", t0, 10);
    chk("b2b_ready_after_xfer", rdy11, 1);
    chk("b2b_second_pt", d1, B_PT);
    chk("b2b_second_cycle", t1, 22);
    chk("b2b_outputs", n_out, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
